// File: rtl/stopwatch_ctrl.sv
// Start/stop/lap/clear sequencer for a cascaded BCD counter chain.
// Divides the clock into count ticks and freezes the display for lap readout.
module stopwatch_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int DIGITS   = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_nRst,
  input  logic                  i_StartStop,
  input  logic                  i_Lap,
  input  logic                  i_Clear,
  input  logic [4*DIGITS-1:0]   i_Digits,
  output logic                  o_CntEn,
  output logic                  o_ClrN,
  output logic [4*DIGITS-1:0]   o_Disp,
  output logic                  o_Running,
  output logic                  o_Lap,
  output logic                  o_Overflow
);

  localparam int            PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_LAP, S_PAUSE, S_OVF, S_CLR
  } state_e;

  state_e              state_q, state_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic [4*DIGITS-1:0] lap_q, lap_d;
  logic                ss_prev_q, lap_prev_q, clr_prev_q;
  logic                clrn_q;

  logic ev_clr, ev_ss_raw, ev_ss, ev_lap;
  logic running, tick, all_nine, ovf_cond;
  logic [DIGITS-1:0] digit_nine;

  // Clear outranks StartStop, which outranks Lap; losers are dropped.
  assign ev_clr    = i_Clear & ~clr_prev_q;
  assign ev_ss_raw = i_StartStop & ~ss_prev_q;
  assign ev_ss     = ev_ss_raw & ~ev_clr;
  assign ev_lap    = i_Lap & ~lap_prev_q & ~ev_clr & ~ev_ss_raw;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nine
    assign digit_nine[gi] = (i_Digits[4*gi +: 4] == 4'd9);
  end

  assign all_nine = &digit_nine;
  assign running  = (state_q == S_RUN) || (state_q == S_LAP);
  assign tick     = running && (pre_q == PMAX);
  assign ovf_cond = tick & all_nine;

  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      lap_q      <= '0;
      ss_prev_q  <= 1'b0;
      lap_prev_q <= 1'b0;
      clr_prev_q <= 1'b0;
      clrn_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      lap_q      <= lap_d;
      ss_prev_q  <= i_StartStop;
      lap_prev_q <= i_Lap;
      clr_prev_q <= i_Clear;
      clrn_q     <= (state_d != S_CLR);
    end
  end

  always_comb begin
    state_d = state_q;
    lap_d   = lap_q;
    pre_d   = pre_q;
    case (state_q)
      S_IDLE: begin
        if (ev_clr)     state_d = S_CLR;
        else if (ev_ss) state_d = S_RUN;
      end
      S_RUN: begin
        if (ovf_cond)   state_d = S_OVF;
        else if (ev_ss) state_d = S_PAUSE;
        else if (ev_lap) begin
          state_d = S_LAP;
          lap_d   = i_Digits;
        end
      end
      S_LAP: begin
        if (ovf_cond)    state_d = S_OVF;
        else if (ev_ss)  state_d = S_PAUSE;
        else if (ev_lap) state_d = S_RUN;
      end
      S_PAUSE: begin
        if (ev_clr)     state_d = S_CLR;
        else if (ev_ss) state_d = S_RUN;
      end
      S_OVF: begin
        if (ev_clr) state_d = S_CLR;
      end
      S_CLR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // The prescaler only moves while timing, so pause keeps the tick phase.
    if (running)                pre_d = (pre_q == PMAX) ? '0 : pre_q + PW'(1);
    else if (state_q == S_CLR)  pre_d = '0;
  end

  always_comb begin
    o_CntEn    = tick & ~all_nine;
    o_ClrN     = clrn_q;
    o_Running  = running;
    o_Lap      = (state_q == S_LAP);
    o_Overflow = (state_q == S_OVF);
    o_Disp     = (state_q == S_LAP) ? lap_q : i_Digits;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a behavioural BCD chain plus an elapsed-time
// reference model checked every cycle under directed and random button use.
module tb_stopwatch_ctrl;
  localparam int P = 4;
  localparam int D = 2;
  localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3, M_OVF = 4, M_CLR = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ss = 1'b0, lp = 1'b0, cl = 1'b0;
  logic [4*D-1:0] digits;
  logic         cnt_en, clr_n, running, lap_o, ovf;
  logic [4*D-1:0] disp;
  logic         chain_rstn;

  int checks = 0;
  int errors = 0;

  int   m_mode, m_phase, m_count, m_lap;
  logic m_ps, m_pl, m_pc;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.PRESCALE(P), .DIGITS(D)) dut (
    .i_Clk(clk), .i_nRst(rst_n), .i_StartStop(ss), .i_Lap(lp), .i_Clear(cl),
    .i_Digits(digits), .o_CntEn(cnt_en), .o_ClrN(clr_n), .o_Disp(disp),
    .o_Running(running), .o_Lap(lap_o), .o_Overflow(ovf)
  );

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] hi, lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  // Counter chain in the environment, reset as i_nRst AND o_ClrN.
  assign chain_rstn = rst_n & clr_n;
  always @(posedge clk or negedge chain_rstn) begin
    if (!chain_rstn)  digits <= '0;
    else if (cnt_en)  digits <= bcd_inc(digits);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_phase = 0; m_count = 0; m_lap = 0;
    m_ps = 1'b0; m_pl = 1'b0; m_pc = 1'b0;
  endtask

  // One clock: drive buttons, check all outputs against the model, advance model.
  task automatic cyc(input logic s, input logic l, input logic c);
    logic e_ss, e_lap, e_clr, tick, nine, x_en, timing;
    int nmode, nphase, ncount, nlap;
    ss = s; lp = l; cl = c;
    @(negedge clk);
    e_clr  = c & ~m_pc;
    e_ss   = s & ~m_ps & ~e_clr;
    e_lap  = l & ~m_pl & ~e_clr & ~(s & ~m_ps);
    timing = (m_mode == M_RUN) || (m_mode == M_LAP);
    tick   = timing && (m_phase == P - 1);
    nine   = (m_count == 99);
    x_en   = tick && !nine;
    chk("cnt_en",  {31'd0, cnt_en},  {31'd0, x_en});
    chk("clr_n",   {31'd0, clr_n},   {31'd0, m_mode != M_CLR});
    chk("running", {31'd0, running}, {31'd0, timing});
    chk("lap",     {31'd0, lap_o},   {31'd0, m_mode == M_LAP});
    chk("ovf",     {31'd0, ovf},     {31'd0, m_mode == M_OVF});
    chk("digits",  {24'd0, digits},  {24'd0, to_bcd(m_count)});
    chk("disp",    {24'd0, disp},    {24'd0, (m_mode == M_LAP) ? to_bcd(m_lap) : to_bcd(m_count)});
    nmode = m_mode; nlap = m_lap;
    case (m_mode)
      M_IDLE:  if (e_clr) nmode = M_CLR; else if (e_ss) nmode = M_RUN;
      M_RUN:   if (tick && nine) nmode = M_OVF;
               else if (e_ss) nmode = M_PAUSE;
               else if (e_lap) begin nmode = M_LAP; nlap = m_count; end
      M_LAP:   if (tick && nine) nmode = M_OVF;
               else if (e_ss) nmode = M_PAUSE;
               else if (e_lap) nmode = M_RUN;
      M_PAUSE: if (e_clr) nmode = M_CLR; else if (e_ss) nmode = M_RUN;
      M_OVF:   if (e_clr) nmode = M_CLR;
      default: nmode = M_IDLE;
    endcase
    nphase = m_phase;
    if (timing)               nphase = (m_phase + 1) % P;
    else if (m_mode == M_CLR) nphase = 0;
    ncount = m_count + (x_en ? 1 : 0);
    if (nmode == M_CLR) ncount = 0;
    @(posedge clk);
    #1;
    m_mode = nmode; m_phase = nphase; m_count = ncount; m_lap = nlap;
    m_ps = s; m_pl = l; m_pc = c;
  endtask

  initial begin
    int g;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt_en",  {31'd0, cnt_en},  32'd0);
    chk("rst_clr_n",   {31'd0, clr_n},   32'd1);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_disp",    {24'd0, disp},    32'd0);
    rst_n = 1'b1;

    // Start and count 25 ticks.
    cyc(1, 0, 0);
    repeat (3) cyc(1, 0, 0);
    repeat (97) cyc(0, 0, 0);
    chk("count25",   {24'd0, digits},  32'h25);
    chk("running25", {31'd0, running}, 32'd1);

    // Asynchronous reset in the middle of RUN.
    repeat (2) cyc(0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_cnt_en",  {31'd0, cnt_en},  32'd0);
    chk("mid_rst_clr_n",   {31'd0, clr_n},   32'd1);
    chk("mid_rst_running", {31'd0, running}, 32'd0);
    chk("mid_rst_lap",     {31'd0, lap_o},   32'd0);
    chk("mid_rst_ovf",     {31'd0, ovf},     32'd0);
    chk("mid_rst_disp",    {24'd0, disp},    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();

    // Pause with prescaler at 2, resume, expect a pulse two running cycles later.
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (10) cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("resume_no_pulse", {31'd0, cnt_en}, 32'd0);
    cyc(0, 0, 0);
    chk("resume_pulse", {31'd0, cnt_en}, 32'd1);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    chk("pause_clr_n", {31'd0, clr_n}, 32'd0);
    cyc(0, 0, 0);
    chk("idle_digits", {24'd0, digits}, 32'h00);

    // Lap capture at 13, hold while chain reaches 17, release on second Lap.
    cyc(1, 0, 0);
    g = 0;
    while (m_count < 13 && g < 1000) begin cyc(0, 0, 0); g++; end
    chk("reach13", {24'd0, digits}, 32'h13);
    cyc(0, 1, 0);
    g = 0;
    while (m_count < 17 && g < 1000) begin cyc(0, 0, 0); g++; end
    chk("lap_disp",   {24'd0, disp},   32'h13);
    chk("lap_digits", {24'd0, digits}, 32'h17);
    chk("lap_flag",   {31'd0, lap_o},  32'd1);
    cyc(0, 1, 0);
    chk("lap2_flag", {31'd0, lap_o}, 32'd0);
    chk("lap2_disp", {24'd0, disp},  {24'd0, to_bcd(m_count)});

    // Run into overflow, StartStop ignored, then clear.
    g = 0;
    while (m_mode != M_OVF && g < 2000) begin cyc(0, 0, 0); g++; end
    chk("ovf_flag",   {31'd0, ovf},    32'd1);
    chk("ovf_digits", {24'd0, digits}, 32'h99);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("ovf_hold",   {31'd0, ovf},    32'd1);
    chk("ovf_hold99", {24'd0, digits}, 32'h99);
    cyc(0, 0, 1);
    chk("clr_low",    {31'd0, clr_n},  32'd0);
    chk("clr_digits", {24'd0, digits}, 32'h00);
    cyc(0, 0, 0);
    chk("clr_high",   {31'd0, clr_n},  32'd1);
    chk("clr_idle",   {31'd0, running}, 32'd0);

    // Clear beats StartStop in PAUSE; Clear alone is ignored in RUN.
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 1);
    chk("prio_clr",  {31'd0, clr_n},   32'd0);
    chk("prio_norun", {31'd0, running}, 32'd0);
    cyc(0, 0, 0);
    chk("prio_idle", {31'd0, running}, 32'd0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("run_clr_ignored", {31'd0, running}, 32'd1);
    chk("run_clr_n",       {31'd0, clr_n},   32'd1);

    // Random button activity against the model.
    for (int i = 0; i < 1500; i++) begin
      cyc(($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
          ($urandom_range(0, 11) == 0) ? 1'b1 : 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for a chain of cascaded single-digit BCD counters, forming a start/stop/lap/clear stopwatch. It divides the system clock into a count tick and drives the chain's least-significant-digit enable. It also issues a registered clear to the chain and freezes the displayed value for lap readout. It sits between the debounced user buttons and the counter chain, feeding the display mux.

## Interface
- PRESCALE, 100000: clock cycles per count tick, ≥2.
- DIGITS, 4: number of BCD digits in the chain, ≥1.
- i_Clk  in  1  system clock, rising edge.
- i_nRst  in  1  reset, asynchronous, active-low.
- i_StartStop  in  1  debounced, clock-synchronous button level.
- i_Lap  in  1  debounced, clock-synchronous button level.
- i_Clear  in  1  debounced, clock-synchronous button level.
- i_Digits  in  4*DIGITS  registered counter-chain outputs, digit 0 in bits [3:0].
- o_CntEn  out  1  enable to digit 0 of the chain.
- o_ClrN  out  1  active-low clear for the chain. Integrated as chain reset = i_nRst AND o_ClrN.
- o_Disp  out  4*DIGITS  value to display.
- o_Running  out  1  high in RUN or LAP.
- o_Lap  out  1  high in LAP.
- o_Overflow  out  1  high in OVF.

## Operation
- Edge detect: each button has a registered previous sample. An event is input high while the previous sample is low. Holding a button produces exactly one event.
- Event priority, when events coincide: Clear > StartStop > Lap. The lower-priority events are discarded that cycle.
- States: IDLE, RUN, LAP, PAUSE, OVF, CLR. Reset state is IDLE.
- IDLE: StartStop -> RUN. Clear -> CLR.
- RUN: StartStop -> PAUSE. Lap -> LAP, capturing i_Digits into the lap register. Overflow condition -> OVF.
- LAP: Lap -> RUN. StartStop -> PAUSE. Overflow condition -> OVF.
- PAUSE: StartStop -> RUN. Clear -> CLR.
- OVF: Clear -> CLR. All other events are ignored.
- CLR: unconditionally -> IDLE after one cycle.
- Clear is ignored in RUN and LAP.
- Prescaler: counts 0..PRESCALE-1 and wraps, advancing only in RUN and LAP. It holds its value in PAUSE, IDLE and OVF, and is zeroed in CLR.
- Tick: prescaler == PRESCALE-1 while in RUN or LAP.
- o_CntEn: tick AND NOT all-nines. All-nines means every digit of i_Digits equals 9.
- Overflow condition: tick AND all-nines. The chain is not enabled and holds at all nines, with no wrap to zero.
- o_ClrN: registered output, low exactly during the CLR cycle, high otherwise.
- o_Disp: the lap register in LAP, otherwise i_Digits unchanged.
- o_Running, o_Lap, o_Overflow: decoded from the registered state.
- Width rule: prescaler width is clog2(PRESCALE).
- i_Digits values outside 0–9 are treated as "not nine".

## Timing
- Reset values: state IDLE, prescaler 0, lap register 0, previous samples 0. o_CntEn=0, o_ClrN=1, o_Running=0, o_Lap=0, o_Overflow=0, o_Disp=i_Digits.
- Button latency: the state changes at the first rising edge that samples the button high after a low sample.
- Count latency: RUN is entered at edge k. o_CntEn is high for one cycle between edges k+PRESCALE-1 and k+PRESCALE, so the chain increments at edge k+PRESCALE. Thereafter the chain increments every PRESCALE cycles.
- o_CntEn is never high for two consecutive cycles.
- o_CntEn has no combinational path from the button inputs.
- Pause/resume keeps the tick phase: the elapsed partial period is preserved.
- Lap capture takes the i_Digits value present in the cycle before the entry edge.
- If a tick and a Lap event coincide, the capture takes the pre-increment value.
- StartStop coinciding with a tick in RUN: the state moves to PAUSE and the o_CntEn pulse of that cycle is still issued.
- Reset mid-operation: all registers take their reset values immediately (asynchronous). The chain is reset by i_nRst directly.

## Test plan
- Reset: run with PRESCALE=4, DIGITS=2, assert i_nRst low mid-RUN -> all outputs at reset values, o_ClrN=1, o_CntEn=0, prescaler 0.
- Start/count: StartStop event at edge k -> o_CntEn pulses at k+3, k+7, … After 25 pulses, i_Digits=0x25 and o_Running=1.
- Pause phase: pause 2 cycles after start (prescaler=2), wait 10 cycles, resume -> next o_CntEn pulse exactly 2 running cycles after resume; no pulses while paused.
- Lap: Lap event at digits 0x13 -> o_Disp holds 0x13 while i_Digits reaches 0x17. Second Lap -> o_Disp follows i_Digits the same cycle, o_Lap=0.
- Overflow/clear: digits 0x99 at tick -> no o_CntEn, o_Overflow=1, chain stays 0x99, StartStop ignored. Clear -> o_ClrN low one cycle, then IDLE with digits 0x00.
- Priority: in PAUSE, raise Clear and StartStop in the same cycle -> CLR then IDLE, never RUN. In RUN, Clear alone -> no state change.
